// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: latches one draw command, clips it to the screen and streams
// fill or outline pixels into a frame buffer write port with valid/ready backpressure.
module rect_draw_engine #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 12,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_mode,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam logic [CW1-1:0]    X_MAX  = CW1'(H_RES - 1);
    localparam logic [CW1-1:0]    Y_MAX  = CW1'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {StIdle, StSetup, StDraw, StFinish} state_e;
    state_e state_q, state_d;

    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
    logic [COLOR_W-1:0] color_q;
    logic               mode_q;
    logic [COORD_W-1:0] x_last_q, y_last_q;
    logic               right_vis_q, bottom_vis_q;
    logic [ADDR_W-1:0]  row_base_q;
    logic [COORD_W-1:0] cur_x_q, cur_y_q;

    // Setup-cycle arithmetic, one bit wider so x+w-1 cannot overflow before clipping
    logic [CW1-1:0]     x_sum, y_sum;
    logic               right_in, bottom_in, empty_cmd;
    logic [COORD_W-1:0] x_last_d, y_last_d;

    always_comb begin
        x_sum     = {1'b0, x_q} + {1'b0, w_q} - CW1'(1);
        y_sum     = {1'b0, y_q} + {1'b0, h_q} - CW1'(1);
        right_in  = (x_sum <= X_MAX);
        bottom_in = (y_sum <= Y_MAX);
        x_last_d  = right_in ? x_sum[COORD_W-1:0] : X_MAX[COORD_W-1:0];
        y_last_d  = bottom_in ? y_sum[COORD_W-1:0] : Y_MAX[COORD_W-1:0];
        empty_cmd = (w_q == '0) || (h_q == '0) || ({1'b0, x_q} > X_MAX) ||
                    ({1'b0, y_q} > Y_MAX);
    end

    // Pixel walk: outline interior rows hop from the left column straight to the right one
    logic               accept, full_row, row_end, last_pixel, can_jump;
    logic [COORD_W-1:0] next_x;

    always_comb begin
        accept   = (state_q == StDraw) && wr_ready;
        full_row = !mode_q || (cur_y_q == y_q) || (bottom_vis_q && (cur_y_q == y_last_q));
        can_jump = (cur_x_q == x_q) && right_vis_q && (w_q > COORD_W'(1));
        if (full_row) begin
            row_end = (cur_x_q == x_last_q);
            next_x  = cur_x_q + COORD_W'(1);
        end else begin
            row_end = !can_jump;
            next_x  = x_last_q;
        end
        last_pixel = row_end && (cur_y_q == y_last_q);
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = empty_cmd ? StFinish : StDraw;
            end
            StDraw: begin
                if (accept && last_pixel) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_valid = (state_q == StDraw);
        busy     = (state_q != StIdle);
        wr_addr  = row_base_q + ADDR_W'(cur_x_q);
        wr_data  = color_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            mode_q       <= 1'b0;
            x_last_q     <= '0;
            y_last_q     <= '0;
            right_vis_q  <= 1'b0;
            bottom_vis_q <= 1'b0;
            row_base_q   <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
        end else begin
            if (state_q == StIdle && cmd_valid) begin
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
                mode_q  <= cmd_mode;
            end
            if (state_q == StSetup) begin
                x_last_q     <= x_last_d;
                y_last_q     <= y_last_d;
                right_vis_q  <= right_in;
                bottom_vis_q <= bottom_in;
                // The only multiply: once per command, never inside the pixel loop
                row_base_q   <= ADDR_W'(y_q) * H_STEP;
                cur_x_q      <= x_q;
                cur_y_q      <= y_q;
            end
            if (accept && !last_pixel) begin
                if (row_end) begin
                    cur_x_q    <= x_q;
                    cur_y_q    <= cur_y_q + COORD_W'(1);
                    row_base_q <= row_base_q + H_STEP;
                end else begin
                    cur_x_q <= next_x;
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Self-checking bench for rect_draw_engine: directed scenarios plus random commands,
// checked every cycle against a pixel-list model built by enumerating the rectangle.
module tb_rect_draw_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic        cmd_mode = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    rect_draw_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .cmd_mode  (cmd_mode),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backpressure source: ~50% ready when bp_mode is set, else always ready
    bit bp_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model: expected pixel queue, plus coarse command phase for timing
    int m_x, m_y, m_w, m_h, m_mode;
    int m_color;
    int q[$];
    int log_q[$];
    int phase = 0;  // 0 idle, 1 setup, 2 drawing, 3 done cycle
    int cyc = 0;
    int done_cnt = 0, acc_cnt = 0;
    int accept_cyc = 0, done_cyc = 0, first_cyc = -1, last_acc_cyc = 0;
    bit prev_stall = 1'b0;
    int prev_addr = 0;

    function automatic void build_list();
        int xe, ye;
        q.delete();
        if (m_w == 0 || m_h == 0) return;
        xe = (m_x + m_w < 640) ? m_x + m_w : 640;
        ye = (m_y + m_h < 480) ? m_y + m_h : 480;
        for (int yy = m_y; yy < ye; yy++)
            for (int xx = m_x; xx < xe; xx++)
                if (m_mode == 0 || yy == m_y || yy == m_y + m_h - 1 ||
                    xx == m_x || xx == m_x + m_w - 1)
                    q.push_back(yy * 640 + xx);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_wr_valid", 32'(wr_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_cmd_ready", 32'(cmd_ready), 1);
            chk("rst_done", 32'(done), 0);
            q.delete();
            phase = 0;
            prev_stall = 1'b0;
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(phase == 0));
            chk("busy", 32'(busy), 32'(phase != 0));
            chk("done", 32'(done), 32'(phase == 3));
            chk("wr_valid", 32'(wr_valid), 32'(phase == 2));
            if (done) done_cnt++;
            if (wr_valid && first_cyc < 0) first_cyc = cyc;
            case (phase)
                0: if (cmd_valid) begin
                    m_x = cmd_x; m_y = cmd_y; m_w = cmd_w; m_h = cmd_h;
                    m_color = cmd_color; m_mode = cmd_mode;
                    accept_cyc = cyc;
                    first_cyc = -1;
                    phase = 1;
                end
                1: begin
                    build_list();
                    phase = (q.size() > 0) ? 2 : 3;
                end
                2: begin
                    if (prev_stall) chk("hold_addr", 32'(wr_addr), prev_addr);
                    if (q.size() > 0) begin
                        chk("wr_addr", 32'(wr_addr), q[0]);
                        chk("wr_data", 32'(wr_data), m_color);
                    end
                    prev_stall = !wr_ready;
                    prev_addr = wr_addr;
                    if (wr_ready) begin
                        log_q.push_back(int'(wr_addr));
                        acc_cnt++;
                        last_acc_cyc = cyc;
                        if (q.size() > 0) void'(q.pop_front());
                        if (q.size() == 0) begin
                            phase = 3;
                            prev_stall = 1'b0;
                        end
                    end
                end
                default: begin
                    done_cyc = cyc;
                    phase = 0;
                end
            endcase
        end
    end

    task automatic send(input int x, input int y, input int w, input int h,
                        input int color, input int mode);
        int i;
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_color = 12'(color); cmd_mode = 1'(mode);
        cmd_valid = 1'b1;
        for (i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (i == 30000) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Scramble inputs after acceptance: the command in flight must not notice
        cmd_x = 10'($urandom); cmd_y = 10'($urandom); cmd_w = 10'($urandom);
        cmd_h = 10'($urandom); cmd_color = 12'($urandom); cmd_mode = 1'($urandom);
    endtask

    task automatic wait_done(input int start);
        int i;
        for (i = 0; i < 30000; i++) begin
            @(posedge clk);
            if (done_cnt > start) break;
        end
        if (i == 30000) chk("done_timeout", 1, 0);
        #1;
    endtask

    task automatic run(input int x, input int y, input int w, input int h,
                       input int color, input int mode);
        int start;
        log_q.delete();
        start = done_cnt;
        send(x, y, w, h, color, mode);
        wait_done(start);
        @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - start), 1);
    endtask

    task automatic expect_log(input string name, input int exp[$]);
        chk({name, "_count"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(name, 32'(log_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int e[$];
        int start;
        int i;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_data", 32'(wr_data), 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill 4x2 at (10,20)
        run(10, 20, 4, 2, 12'hF00, 0);
        e = '{12810, 12811, 12812, 12813, 13450, 13451, 13452, 13453};
        expect_log("fill_addr", e);
        chk("fill_latency", 32'(first_cyc - accept_cyc), 2);
        chk("fill_consecutive", 32'(last_acc_cyc - first_cyc), 7);
        chk("fill_done_after_last", 32'(done_cyc - last_acc_cyc), 1);

        // Clipping
        run(638, 478, 4, 4, 12'h0A5, 0);
        e = '{306558, 306559, 307198, 307199};
        expect_log("clip_addr", e);
        run(700, 10, 5, 5, 12'h123, 0);
        chk("offscreen_writes", 32'(log_q.size()), 0);

        // Outline
        run(0, 0, 4, 3, 12'h0F0, 1);
        e = '{0, 1, 2, 3, 640, 643, 1280, 1281, 1282, 1283};
        expect_log("outline_addr", e);
        run(5, 5, 1, 3, 12'h00F, 1);
        e = '{3205, 3845, 4485};
        expect_log("outline_1x3", e);

        // Backpressure
        bp_mode = 1'b1;
        run(0, 0, 3, 1, 12'hABC, 0);
        e = '{0, 1, 2};
        expect_log("bp_addr", e);
        bp_mode = 1'b0;

        // Zero size
        run(3, 3, 0, 7, 12'h111, 0);
        chk("zero_writes", 32'(log_q.size()), 0);
        chk("zero_done_delay", 32'(done_cyc - accept_cyc), 2);

        // Second command held during busy
        log_q.delete();
        start = done_cnt;
        send(0, 0, 5, 2, 12'h222, 0);
        send(20, 1, 3, 1, 12'h333, 0);
        chk("blocked_accept", 32'(accept_cyc - done_cyc), 1);
        wait_done(start + 1);
        chk("blocked_total", 32'(log_q.size()), 13);
        @(posedge clk);
        #1;

        // Reset mid-command after 37 writes
        log_q.delete();
        acc_cnt = 0;
        start = done_cnt;
        send(10, 10, 100, 100, 12'h777, 0);
        for (i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt >= 37) break;
        end
        chk("mid_reset_reach", 32'(acc_cnt), 37);
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", 32'(wr_valid), 0);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_writes", 32'(log_q.size()), 37);
        chk("mid_reset_no_done", 32'(done_cnt - start), 0);
        run(0, 0, 1, 1, 12'hFFF, 0);
        e = '{0};
        expect_log("after_reset", e);

        // Random commands, biased toward screen edges
        for (int n = 0; n < 40; n++) begin
            int rx, ry;
            bp_mode = 1'($urandom_range(0, 1));
            rx = $urandom_range(0, 1) ? $urandom_range(600, 700) : $urandom_range(0, 60);
            ry = $urandom_range(0, 1) ? $urandom_range(440, 500) : $urandom_range(0, 60);
            run(rx, ry, $urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 4095), $urandom_range(0, 1));
        end
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
